// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the MIPS core fetch path: FSM encoding,
// sequential PC increment and word-alignment mask.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INC = 4;

  // Low address bits that must be zero for a word-aligned instruction address
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: reads the instruction at PC from a handshaked
// instruction memory, presents it to the decoder and computes nextPC so
// that the PC register (loaded every cycle) only advances on handoff.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] nextPC,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemAck,
  input  logic [DATA_W-1:0] ImemRdata,
  output logic [DATA_W-1:0] Instr,
  output logic              InstrValid,
  input  logic              InstrReady,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              AlignErr
);

  fetch_state_t state, state_nxt;
  logic              handoff;
  logic              misaligned;
  logic [ADDR_W-1:0] target;

  // Redirect target is forced word-aligned; sequential path wraps naturally
  assign misaligned = |(BranchTarget[1:0] & ALIGN_MASK);
  assign target     = BranchTaken ? {BranchTarget[ADDR_W-1:2], 2'b00}
                                  : ImemAddr + ADDR_W'(PC_INC);

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (ImemAck) state_nxt = VALID;
      VALID:   if (InstrReady) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state: ImemReq and InstrValid fall
  // the instant reset asserts because the state register clears asynchronously
  always_comb begin
    ImemReq    = (state == REQ);
    InstrValid = (state == VALID);
    handoff    = (state == VALID) && InstrReady;
    nextPC     = handoff ? target : PC;
  end

  // Fetch address, instruction and alignment-error registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ImemAddr <= '0;
      Instr    <= '0;
      AlignErr <= 1'b0;
    end else begin
      AlignErr <= 1'b0;
      case (state)
        IDLE: ImemAddr <= PC;
        REQ:  if (ImemAck) Instr <= ImemRdata;
        VALID: begin
          if (InstrReady) begin
            ImemAddr <= target;
            AlignErr <= BranchTaken && misaligned;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: models the PC register around the DUT and
// checks each fetch transaction against expected addresses, data and nextPC.
module tb_fetch_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [AW-1:0] PC, nextPC, ImemAddr, BranchTarget;
  logic          ImemReq, ImemAck, InstrValid, InstrReady, BranchTaken, AlignErr;
  logic [DW-1:0] ImemRdata, Instr;

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst), .PC(PC), .nextPC(nextPC),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck),
    .ImemRdata(ImemRdata), .Instr(Instr), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .AlignErr(AlignErr)
  );

  always #5 Clk = ~Clk;

  // PC register loaded from nextPC every cycle
  logic [AW-1:0] pc_rst = '0;
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) PC <= pc_rst;
    else      PC <= nextPC;
  end

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr;
  logic          align_now = 1'b0;
  logic          align_next = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    align_now  = align_next;
    align_next = 1'b0;
  endtask

  task automatic apply_reset(input logic [AW-1:0] rv);
    pc_rst      = rv;
    ImemAck     = 1'b0;
    InstrReady  = 1'b0;
    BranchTaken = 1'b0;
    Rst         = 1'b0;
    align_now   = 1'b0;
    align_next  = 1'b0;
    repeat (2) tick();
    @(negedge Clk);
    chk("rst_req",    32'(ImemReq), 0);
    chk("rst_valid",  32'(InstrValid), 0);
    chk("rst_addr",   ImemAddr, 0);
    chk("rst_instr",  Instr, 0);
    chk("rst_align",  32'(AlignErr), 0);
    chk("rst_nextpc", nextPC, rv);
    Rst = 1'b1;
    #1;
    chk("idle_req",    32'(ImemReq), 0);
    chk("idle_nextpc", nextPC, rv);
    tick();
    exp_addr = rv;
  endtask

  // One complete fetch: `waits` cycles before ack, `stalls` cycles of
  // decoder back-pressure, then handoff with the given redirect inputs.
  task automatic fetch(input int waits, input int stalls, input logic br,
                       input logic [AW-1:0] tgt, input logic [DW-1:0] data);
    logic [AW-1:0] target;
    for (int i = 0; i <= waits; i++) begin
      ImemAck      = (i == waits);
      ImemRdata    = (i == waits) ? data : DW'($urandom);
      InstrReady   = 1'($urandom);
      BranchTaken  = 1'($urandom);
      BranchTarget = AW'($urandom);
      @(negedge Clk);
      chk("req_req",    32'(ImemReq), 1);
      chk("req_addr",   ImemAddr, exp_addr);
      chk("req_pc",     PC, exp_addr);
      chk("req_valid",  32'(InstrValid), 0);
      chk("req_nextpc", nextPC, PC);
      chk("req_align",  32'(AlignErr), 32'(align_now));
      tick();
    end
    for (int i = 0; i < stalls; i++) begin
      ImemAck      = 1'($urandom);
      ImemRdata    = DW'($urandom);
      InstrReady   = 1'b0;
      BranchTaken  = 1'($urandom);
      BranchTarget = AW'($urandom);
      @(negedge Clk);
      chk("stall_valid",  32'(InstrValid), 1);
      chk("stall_instr",  Instr, data);
      chk("stall_req",    32'(ImemReq), 0);
      chk("stall_nextpc", nextPC, PC);
      chk("stall_align",  32'(AlignErr), 32'(align_now));
      tick();
    end
    ImemAck      = 1'($urandom);
    ImemRdata    = DW'($urandom);
    InstrReady   = 1'b1;
    BranchTaken  = br;
    BranchTarget = tgt;
    target = br ? (tgt & ~32'd3) : exp_addr + 32'd4;
    @(negedge Clk);
    chk("ho_valid",  32'(InstrValid), 1);
    chk("ho_instr",  Instr, data);
    chk("ho_req",    32'(ImemReq), 0);
    chk("ho_nextpc", nextPC, target);
    chk("ho_align",  32'(AlignErr), 32'(align_now));
    align_next = br && (tgt[1:0] != 2'b00);
    tick();
    exp_addr = target;
  endtask

  initial begin
    ImemAck = 1'b0; ImemRdata = '0; InstrReady = 1'b0;
    BranchTaken = 1'b0; BranchTarget = '0;
    #1;
    apply_reset(32'h0000_0000);

    // Directed cases
    fetch(2, 0, 1'b0, 32'h0, 32'h1234_5678);
    fetch(0, 3, 1'b0, 32'h0, 32'hCAFE_0001);
    fetch(1, 0, 1'b1, 32'h0000_0040, 32'hCAFE_0002);
    fetch(0, 0, 1'b1, 32'h0000_0046, 32'hCAFE_0003);
    fetch(0, 1, 1'b0, 32'h0, 32'hCAFE_0004);

    // Sequential wrap at the top of the address space
    apply_reset(32'hFFFF_FFFC);
    fetch(0, 0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    fetch(1, 0, 1'b0, 32'h0, 32'hDEAD_BEF0);

    // Randomized fetch stream
    for (int n = 0; n < 150; n++) begin
      fetch(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), AW'($urandom), DW'($urandom));
    end

    // Reset between edges while a fetch is outstanding
    ImemAck = 1'b0;
    InstrReady = 1'b0;
    @(negedge Clk);
    chk("pre_req", 32'(ImemReq), 1);
    #2;
    pc_rst = 32'h0000_0100;
    Rst = 1'b0;
    #1;
    chk("async_req",   32'(ImemReq), 0);
    chk("async_addr",  ImemAddr, 0);
    chk("async_pc",    PC, 32'h0000_0100);
    ImemAck   = 1'b1;
    ImemRdata = 32'hBAD0_BAD0;
    repeat (2) @(posedge Clk);
    #1;
    chk("late_ack_valid", 32'(InstrValid), 0);
    chk("late_ack_instr", Instr, 0);
    apply_reset(32'h0000_0100);
    fetch(1, 1, 1'b0, 32'h0, 32'h0BAD_F00D);
    fetch(0, 0, 1'b0, 32'h0, 32'h0BAD_F00E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch controller on the far side of the PC register: consumes the current PC, fetches the instruction from a handshaked instruction memory, and hands it to the decoder.
- Produces nextPC for the PC register. While a fetch or handoff is pending it holds nextPC = PC. On handoff it advances nextPC to PC+4 or to the branch/jump target.
- Makes the PC register's plain "load every cycle" interface usable with multi-cycle memory and a back-pressuring decoder.

Parameters:
- ADDR_W, 32, width of PC, nextPC and memory address.
- DATA_W, 32, instruction width.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low (0 = reset).
- PC  in  ADDR_W  current PC from the PC register.
- nextPC  out  ADDR_W  value loaded into the PC register at the next edge.
- ImemReq  out  1  instruction memory read request.
- ImemAddr  out  ADDR_W  read address, registered.
- ImemAck  in  1  memory has data on ImemRdata this cycle.
- ImemRdata  in  DATA_W  instruction data.
- Instr  out  DATA_W  fetched instruction, registered.
- InstrValid  out  1  Instr is valid for the decoder.
- InstrReady  in  1  decoder accepts Instr.
- BranchTaken  in  1  redirect request, qualified by handoff.
- BranchTarget  in  ADDR_W  redirect address.
- AlignErr  out  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Behaviour:
- FSM states IDLE, REQ, VALID, held in a registered state variable.
- Reset (Rst=0, asynchronous):
  - state = IDLE.
  - ImemReq, InstrValid and AlignErr = 0.
  - ImemAddr and Instr = 0.
  - ImemReq drops immediately, without waiting for a clock edge; any in-flight fetch is abandoned.
- IDLE: first edge with Rst=1 latches ImemAddr <= PC and moves to REQ.
- REQ:
  - ImemReq = 1; ImemAddr stays stable until ack.
  - On an edge with ImemAck=1: Instr <= ImemRdata, InstrValid <= 1, ImemReq <= 0, state -> VALID.
  - Minimum memory latency is 1 cycle (ack in the first REQ cycle). Any number of wait cycles is allowed.
- VALID:
  - InstrValid = 1 and Instr is stable until handoff.
  - Handoff is InstrValid & InstrReady at an edge.
  - Handoff target is (BranchTaken ? {BranchTarget[ADDR_W-1:2],2'b00} : ImemAddr + 4).
  - At the handoff edge: ImemAddr <= target, InstrValid <= 0, state -> REQ. There is no bubble: ImemReq = 1 in the cycle after handoff.
- nextPC (combinational):
  - Equals the handoff target in a handoff cycle; equals PC in every other cycle, including IDLE.
  - So PC and ImemAddr stay equal after each handoff.
- BranchTaken/BranchTarget are ignored outside handoff cycles.
- AlignErr:
  - Pulses 1 cycle after a handoff with BranchTaken=1 and BranchTarget[1:0] != 0.
  - The target is still used with bits [1:0] cleared.
- Arithmetic: PC+4 wraps modulo 2^ADDR_W, so 0xFFFFFFFC -> 0x00000000. No overflow flag.
- ImemAck outside REQ is ignored; Instr is unchanged.
- InstrReady outside VALID is ignored.
- Reset asserted in VALID discards Instr. Reset release restarts from IDLE using whatever PC presents (its reset value).

Decomposition:
- Shared package for the MIPS core:
  - state encoding constants: IDLE=2'd0, REQ=2'd1, VALID=2'd2;
  - PC_INC = 4;
  - word-alignment mask.
- No sub-module. A single FSM-plus-datapath file; nextPC mux is inline.

Test Plan:
- Reset then release, PC=0, ack after 2 wait cycles, InstrReady=1 -> ImemReq high with ImemAddr=0 for 3 cycles; Instr=ImemRdata, InstrValid=1 for 1 cycle; nextPC=4 in the handoff cycle; next ImemAddr=4.
- InstrReady=0 for 3 cycles in VALID -> InstrValid and Instr stable, nextPC==PC every cycle, ImemReq=0; handoff on the 4th cycle -> nextPC=PC+4.
- Handoff with BranchTaken=1, BranchTarget=0x00000040 -> nextPC=0x40, next ImemAddr=0x40, AlignErr stays 0.
- Handoff with BranchTaken=1, BranchTarget=0x00000046 -> nextPC=0x44 and AlignErr=1 for exactly one cycle.
- PC=0xFFFFFFFC, ack, handoff -> nextPC=0x00000000, ImemAddr=0x00000000.
- Rst driven low mid-REQ (between edges) -> ImemReq=0 immediately; a late ImemAck is ignored; InstrValid never rises; after release, fetch restarts at PC's reset value.
